wb_write_port: RTL
==================

# wb_write_port

Writeback-side driver for the register file's single write port. Accepts completed results from the ALU pipe and the memory (load) pipe through valid/ready handshakes and buffers them in a small in-order queue. Drains one entry per cycle onto the register file's `write`/`WR`/`WD` inputs. Also exposes a bypass lookup so decode can read results that are still queued and not yet committed.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; must be 2 or more.
- `DATA_W`, 32: data width.
- `ADDR_W`, 5: register address width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; flushes the queue.
- `mem_valid`  in  1  memory pipe result valid.
- `mem_wr`  in  ADDR_W  memory result destination register.
- `mem_wd`  in  DATA_W  memory result data.
- `mem_ready`  out  1  memory result accepted this cycle when high with `mem_valid`.
- `alu_valid`, `alu_wr`, `alu_wd`, `alu_ready`: same meaning, for the ALU pipe.
- `write`  out  1  register file write enable.
- `WR`  out  ADDR_W  register file write address.
- `WD`  out  DATA_W  register file write data.
- `PR1`, `PR2`  in  ADDR_W  decode read addresses (snooped).
- `byp1_hit`, `byp2_hit`  out  1  a queued entry targets `PR1`/`PR2`.
- `byp1_data`, `byp2_data`  out  DATA_W  newest queued data for `PR1`/`PR2`.
- `count`  out  clog2(DEPTH+1)  stored entries.

## Operation
- **Queue**
  - Circular FIFO with head pointer, tail pointer and `count`.
  - Pointers wrap modulo `DEPTH`.
- **Dequeue**
  - `write = (count != 0) && !reset`, with `WR`/`WD` driven from the head entry.
  - When `count != 0`, the head is popped on every rising edge.
  - The register file never stalls.
- **Ready rules** (computed from registered `count` only)
  - `mem_ready = (count <= DEPTH-1)`.
  - `alu_ready = (count <= DEPTH-2) || (!mem_valid && count <= DEPTH-1)`.
- **Enqueue**
  - Up to two entries per cycle.
  - When both are accepted in the same cycle, the mem entry is written at `tail` and the ALU entry at `tail+1`, so mem is treated as older.
- **R0 filter**
  - A result with destination 0 is handshaken (ready honoured) but never stored.
  - It does not consume a slot and does not change `count`.
- **Count update**
  - `count_next = count + enq_mem + enq_alu - deq`.
  - It never exceeds `DEPTH`, and no entry is ever dropped or reordered.
- **Outputs during and after reset**
  - `write=0`, `count=0`, `byp*_hit=0`, `byp*_data=0`.
  - `WR` and `WD` are 0 when `write=0`.
  - Both ready outputs are 1 after reset.

## Timing
- **Latency**
  - A result accepted at edge N is presented on `write`/`WR`/`WD` for the cycle between edges N and N+1.
  - The register file commits it at edge N+1.
- **Simultaneous accept**: mem commits at N+1, ALU at N+2.
- **Bypass**
  - Combinational over stored entries, including the head currently being written.
  - Entries being enqueued in the current cycle are not visible to bypass.
  - `PR = 0` never hits.
  - With multiple matches, the newest entry (closest to tail) wins.
- **Reset mid-operation**: all entries are discarded, and uncommitted results are lost by design.

## Configuration
- `WB_BYPASS_EN` defined: bypass lookup is implemented as described above.
- Not defined: `byp1_hit`/`byp2_hit` are tied 0 and `byp1_data`/`byp2_data` are tied 0. Decode must stall while `count != 0`.

## Test plan
- **Reset**: assert `reset` for 1 cycle with both valids high. Required: `write=0`, `count=0` after the edge, then both readies 1 with no entries stored from the reset cycle.
- **Single ALU result**: ALU result `WR=4`, `WD=31` for one cycle. Required: `write=1`, `WR=4`, `WD=31` for exactly the next cycle, then `count=0`.
- **Simultaneous results**: mem (1, 20) and ALU (2, 7) in the same cycle. Required:
  - Writes (1, 20) then (2, 7) on consecutive cycles.
  - `count` goes 2, 1, 0.
- **Backpressure**: both valid every cycle for 6 cycles with distinct addresses. Required:
  - `count` goes 2, then 3.
  - `alu_ready=0` once `count=3`.
  - Every accepted entry appears on `WR`/`WD` exactly once, in order.
- **R0 filter plus bypass**:
  - ALU (0, 99): required that `write` never asserts.
  - Then mem (5, 11) and ALU (5, 22) together with `PR1=5`. Required: `byp1_hit=1`, `byp1_data=22` until the 22 entry drains, then `byp1_hit=0`.
  - Without `WB_BYPASS_EN`: required `byp1_hit=0` throughout.
- **Reset mid-operation**: assert `reset` with `count=3`. Required: `write=0` in the reset cycle, `count=0` after it, and none of the old entries are ever written.

Source files
------------

// File: rtl/wb_write_port_if.sv
// Bundle of the writeback handshakes, register-file write port and bypass snoop
// signals for wb_write_port; master = pipes/decode side, slave = the port itself.
interface wb_write_port_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_wr;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_ready;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_wr;
  logic [DATA_W-1:0] alu_wd;
  logic              alu_ready;

  logic              write;
  logic [ADDR_W-1:0] WR;
  logic [DATA_W-1:0] WD;

  logic [ADDR_W-1:0] PR1;
  logic [ADDR_W-1:0] PR2;
  logic              byp1_hit;
  logic              byp2_hit;
  logic [DATA_W-1:0] byp1_data;
  logic [DATA_W-1:0] byp2_data;

  logic [CNT_W-1:0]  count;

  modport master (
    output mem_valid, mem_wr, mem_wd, alu_valid, alu_wr, alu_wd, PR1, PR2,
    input  mem_ready, alu_ready, write, WR, WD,
    input  byp1_hit, byp2_hit, byp1_data, byp2_data, count
  );

  modport slave (
    input  mem_valid, mem_wr, mem_wd, alu_valid, alu_wr, alu_wd, PR1, PR2,
    output mem_ready, alu_ready, write, WR, WD,
    output byp1_hit, byp2_hit, byp1_data, byp2_data, count
  );
endinterface

// File: rtl/wb_write_port.sv
// In-order writeback queue driving the register file's single write port.
// Define WB_BYPASS_EN to enable the decode bypass lookup over queued entries.
module wb_write_port #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic            clk,
  input logic            reset,
  wb_write_port_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] wr_q [DEPTH];
  logic [DATA_W-1:0] wd_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic             mem_ready;
  logic             alu_ready;
  logic             enq_mem;
  logic             enq_alu;
  logic             deq;
  logic             write_en;
  logic [PTR_W-1:0] alu_slot;
  logic [PTR_W-1:0] tail_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Readies look only at the registered count, so the pop this cycle is never
  // credited; mem is older, so it gets the last free slot ahead of the ALU.
  always_comb begin
    mem_ready = (count_q <= CNT_W'(DEPTH - 1));
    alu_ready = (count_q <= CNT_W'(DEPTH - 2)) ||
                (!bus.mem_valid && (count_q <= CNT_W'(DEPTH - 1)));
    enq_mem   = bus.mem_valid && mem_ready && (bus.mem_wr != '0);
    enq_alu   = bus.alu_valid && alu_ready && (bus.alu_wr != '0);
    deq       = (count_q != '0);
    write_en  = deq && !reset;
    alu_slot  = enq_mem ? ptr_inc(tail_q) : tail_q;
    if (enq_alu) begin
      tail_next = ptr_inc(alu_slot);
    end else if (enq_mem) begin
      tail_next = ptr_inc(tail_q);
    end else begin
      tail_next = tail_q;
    end
  end

  always_comb begin
    bus.mem_ready = mem_ready;
    bus.alu_ready = alu_ready;
    bus.write     = write_en;
    bus.WR        = write_en ? wr_q[head_q] : '0;
    bus.WD        = write_en ? wd_q[head_q] : '0;
    bus.count     = reset ? '0 : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_mem) begin
        wr_q[tail_q] <= bus.mem_wr;
        wd_q[tail_q] <= bus.mem_wd;
      end
      if (enq_alu) begin
        wr_q[alu_slot] <= bus.alu_wr;
        wd_q[alu_slot] <= bus.alu_wd;
      end
      if (deq) begin
        head_q <= ptr_inc(head_q);
      end
      tail_q  <= tail_next;
      count_q <= count_q + CNT_W'(enq_mem) + CNT_W'(enq_alu) - CNT_W'(deq);
    end
  end

`ifdef WB_BYPASS_EN
  function automatic logic [PTR_W-1:0] slot_of(input logic [PTR_W-1:0] head, input int offset);
    int sum;
    sum = int'(head) + offset;
    if (sum >= DEPTH) sum = sum - DEPTH;
    return PTR_W'(sum);
  endfunction

  // Walk from head toward tail so a later (newer) match overrides an older one.
  always_comb begin
    bus.byp1_hit  = 1'b0;
    bus.byp2_hit  = 1'b0;
    bus.byp1_data = '0;
    bus.byp2_data = '0;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) < count_q) begin
          if ((bus.PR1 != '0) && (wr_q[slot_of(head_q, i)] == bus.PR1)) begin
            bus.byp1_hit  = 1'b1;
            bus.byp1_data = wd_q[slot_of(head_q, i)];
          end
          if ((bus.PR2 != '0) && (wr_q[slot_of(head_q, i)] == bus.PR2)) begin
            bus.byp2_hit  = 1'b1;
            bus.byp2_data = wd_q[slot_of(head_q, i)];
          end
        end
      end
    end
  end
`else
  logic unused_pr;
  assign unused_pr     = ^{bus.PR1, bus.PR2};
  assign bus.byp1_hit  = 1'b0;
  assign bus.byp2_hit  = 1'b0;
  assign bus.byp1_data = '0;
  assign bus.byp2_data = '0;
`endif
endmodule
